// File: rtl/layer_input_packer.sv
// layer_input_packer
//   Collects one input vector from a serial valid/ready stream, packs it
//   PARALLELISM samples per line into a line buffer, then replays the
//   whole vector as one gap-free burst of NUM_LINES beats for a layer of
//   neurons. The next vector is accepted only after layer_done.
// Ports
//   clk, rst    clock, synchronous active-high reset
//   in_data     serial sample (DATA_WIDTH bits, passed through bit-exact)
//   in_valid    in_data valid
//   in_ready    sample accepted this cycle when in_valid is also high (FILL only)
//   out_data    packed line, lane i = sample line*PARALLELISM+i
//   out_valid   beat valid, NUM_LINES consecutive cycles per vector
//   layer_done  one-cycle pulse from the layer: vector consumed
//   busy        high while bursting or waiting for layer_done
//   done_err    sticky, layer_done seen outside the idle part of WAIT
`timescale 1ns/1ps
module layer_input_packer #(
  parameter int NUM_INPUTS  = 784,
  parameter int DATA_WIDTH  = 16,
  parameter int PARALLELISM = 4
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [DATA_WIDTH-1:0]                 in_data,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  output logic [PARALLELISM-1:0][DATA_WIDTH-1:0] out_data,
  output logic                                  out_valid,
  input  logic                                  layer_done,
  output logic                                  busy,
  output logic                                  done_err
);

  localparam int NUM_LINES = NUM_INPUTS / PARALLELISM;
  localparam int LINE_AW   = $clog2(NUM_LINES + 1);
  localparam int LINE_IW   = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1;
  localparam int SAMP_AW   = (PARALLELISM > 1) ? $clog2(PARALLELISM) : 1;
  localparam logic [LINE_AW-1:0] LAST_LINE = LINE_AW'(NUM_LINES - 1);
  localparam logic [SAMP_AW-1:0] LAST_SAMP = SAMP_AW'(PARALLELISM - 1);

  generate
    if ((NUM_INPUTS % PARALLELISM) != 0) begin : g_bad_params
      $error("layer_input_packer: NUM_INPUTS must be a multiple of PARALLELISM");
    end
  endgenerate

  typedef enum logic [1:0] {ST_FILL, ST_BURST, ST_WAIT} state_t;

  state_t state, state_nxt;

  logic [LINE_AW-1:0] line_cnt;
  logic [SAMP_AW-1:0] samp_cnt;
  logic               accept;

  logic [PARALLELISM-1:0][DATA_WIDTH-1:0] line_buf [NUM_LINES];

  assign accept = in_valid && in_ready;

  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= ST_FILL;
    else     state <= state_nxt;
  end

  // next state
  always_comb begin
    state_nxt = state;
    case (state)
      ST_FILL:  if (accept && samp_cnt == LAST_SAMP && line_cnt == LAST_LINE)
                  state_nxt = ST_BURST;
      ST_BURST: if (line_cnt == LAST_LINE) state_nxt = ST_WAIT;
      // The first WAIT cycle still shows the final registered beat; a
      // layer_done there is an error and must not release the packer.
      ST_WAIT:  if (layer_done && !out_valid) state_nxt = ST_FILL;
      default:  state_nxt = ST_FILL;
    endcase
  end

  // state-decoded outputs
  always_comb begin
    in_ready = (state == ST_FILL);
    busy     = (state != ST_FILL);
  end

  // line buffer, not reset
  always_ff @(posedge clk) begin
    if (state == ST_FILL && accept)
      line_buf[line_cnt[LINE_IW-1:0]][samp_cnt] <= in_data;
  end

  // counters, registered read port, error flag
  always_ff @(posedge clk) begin
    if (rst) begin
      line_cnt  <= '0;
      samp_cnt  <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      done_err  <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      out_data  <= '0;
      case (state)
        ST_FILL: begin
          if (accept) begin
            if (samp_cnt == LAST_SAMP) begin
              samp_cnt <= '0;
              line_cnt <= (line_cnt == LAST_LINE) ? '0 : line_cnt + 1'b1;
            end else begin
              samp_cnt <= samp_cnt + 1'b1;
            end
          end
        end
        ST_BURST: begin
          out_valid <= 1'b1;
          out_data  <= line_buf[line_cnt[LINE_IW-1:0]];
          line_cnt  <= (line_cnt == LAST_LINE) ? '0 : line_cnt + 1'b1;
        end
        default: ;
      endcase
      if (layer_done && !(state == ST_WAIT && !out_valid))
        done_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_layer_input_packer.sv
`timescale 1ns/1ps
module tb_layer_input_packer;

  localparam int DW = 16;
  localparam int P  = 4;
  localparam int NI = 8;
  localparam int NL = NI / P;

  localparam int BIG_NI = 784;
  localparam int BIG_NL = BIG_NI / P;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // small configuration
  logic [DW-1:0]        in_data = '0;
  logic                 in_valid = 1'b0;
  logic                 in_ready;
  logic [P-1:0][DW-1:0] out_data;
  logic                 out_valid;
  logic                 layer_done = 1'b0;
  logic                 busy;
  logic                 done_err;

  // default configuration driving a behavioural neuron
  logic [DW-1:0]        b_in_data = '0;
  logic                 b_in_valid = 1'b0;
  logic                 b_in_ready;
  logic [P-1:0][DW-1:0] b_out_data;
  logic                 b_out_valid;
  logic                 b_layer_done = 1'b0;
  logic                 b_busy;
  logic                 b_done_err;

  layer_input_packer #(.NUM_INPUTS(NI), .DATA_WIDTH(DW), .PARALLELISM(P)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .layer_done(layer_done),
    .busy(busy), .done_err(done_err)
  );

  layer_input_packer dut_big (
    .clk(clk), .rst(rst), .in_data(b_in_data), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .out_data(b_out_data), .out_valid(b_out_valid), .layer_done(b_layer_done),
    .busy(b_busy), .done_err(b_done_err)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // scoreboard for the small instance
  logic [P-1:0][DW-1:0] exp_q [$];

  task automatic push_seq(input logic [DW-1:0] base);
    logic [P-1:0][DW-1:0] b;
    for (int l = 0; l < NL; l++) begin
      for (int i = 0; i < P; i++) b[i] = base + DW'(l * P + i);
      exp_q.push_back(b);
    end
  endtask

  initial begin : monitor
    int run;
    logic [P-1:0][DW-1:0] e;
    run = 0;
    forever begin
      @(negedge clk);
      if (out_valid) begin
        run++;
        if (exp_q.size() == 0) begin
          check("unexpected_beat", 64'(out_data), 64'hDEAD);
        end else begin
          e = exp_q.pop_front();
          check("beat_data", 64'(out_data), 64'(e));
        end
      end else if (run != 0) begin
        check("burst_len", 64'(run), 64'(NL));
        run = 0;
      end
    end
  end

  // caller sits at a negedge; returns at the negedge after acceptance
  task automatic send(input logic [DW-1:0] d);
    int n;
    n = 0;
    in_data = d;
    in_valid = 1'b1;
    while (!in_ready && n < 50) begin @(negedge clk); n++; end
    if (!in_ready) check("send_timeout", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic send_vec(input logic [DW-1:0] base);
    for (int k = 0; k < NI; k++) send(base + DW'(k));
  endtask

  task automatic wait_burst_end();
    int n;
    n = 0;
    while (!out_valid && n < 20) begin @(negedge clk); n++; end
    if (!out_valid) check("burst_start_timeout", 64'(out_valid), 64'd1);
    n = 0;
    while (out_valid && n < 20) begin @(negedge clk); n++; end
    if (out_valid) check("burst_end_timeout", 64'(out_valid), 64'd0);
  endtask

  task automatic pulse_done();
    layer_done = 1'b1;
    @(negedge clk);
    layer_done = 1'b0;
  endtask

  // default-config stimulus / neuron model
  function automatic int big_sample(input int v, input int k);
    return ((k * 37 + v * 11) % 201) - 100;
  endfunction

  function automatic int big_weight(input int k);
    return ((k * 13) % 9) - 4;
  endfunction

  task automatic big_sender();
    int n;
    for (int v = 0; v < 3; v++) begin
      for (int k = 0; k < BIG_NI; k++) begin
        b_in_data = DW'(big_sample(v, k));
        b_in_valid = 1'b1;
        n = 0;
        while (!b_in_ready && n < 1000) begin @(negedge clk); n++; end
        if (!b_in_ready) begin
          check("big_send_timeout", 64'(b_in_ready), 64'd1);
          b_in_valid = 1'b0;
          return;
        end
        @(posedge clk); #1;
        b_in_valid = 1'b0;
        @(negedge clk);
      end
    end
  endtask

  task automatic big_neuron();
    int n, acc, exp_acc, gaps, outvalids;
    outvalids = 0;
    for (int v = 0; v < 3; v++) begin
      exp_acc = 0;
      for (int k = 0; k < BIG_NI; k++) exp_acc += big_sample(v, k) * big_weight(k);
      n = 0;
      while (!b_out_valid && n < 3000) begin @(negedge clk); n++; end
      if (!b_out_valid) begin
        check("big_burst_timeout", 64'(b_out_valid), 64'd1);
        return;
      end
      acc = 0;
      gaps = 0;
      for (int b = 0; b < BIG_NL; b++) begin
        if (!b_out_valid) gaps++;
        for (int i = 0; i < P; i++)
          acc += int'($signed(b_out_data[i])) * big_weight(b * P + i);
        @(negedge clk);
      end
      check("big_gaps", 64'(gaps), 64'd0);
      check("big_tail_low", 64'(b_out_valid), 64'd0);
      b_layer_done = 1'b1;
      outvalids++;
      @(negedge clk);
      b_layer_done = 1'b0;
      check("neuron_result", 64'(acc), 64'(exp_acc));
    end
    check("neuron_outvalids", 64'(outvalids), 64'd3);
  endtask

  initial begin : main
    int n;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // reset state
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done_err", 64'(done_err), 64'd0);

    // T1: back-to-back 1..8, latency, ready low afterwards
    send_vec(16'd1);
    push_seq(16'd1);
    check("t1_lat_gap_cycle", 64'(out_valid), 64'd0);
    check("t1_ready_low", 64'(in_ready), 64'd0);
    @(negedge clk);
    check("t1_lat_first_beat", 64'(out_valid), 64'd1);
    wait_burst_end();
    check("t1_wait_busy", 64'(busy), 64'd1);
    check("t1_wait_ready", 64'(in_ready), 64'd0);

    // T2: sample held in WAIT is not consumed until after layer_done
    in_data = 16'd9;
    in_valid = 1'b1;
    n = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (in_ready) n++;
    end
    check("t2_ready_cycles_in_wait", 64'(n), 64'd0);
    pulse_done();
    check("t2_ready_after_done", 64'(in_ready), 64'd1);
    check("t2_busy_after_done", 64'(busy), 64'd0);
    send(16'd9);
    for (int k = 1; k < NI; k++) send(16'd9 + 16'(k));
    push_seq(16'd9);
    wait_burst_end();
    pulse_done();

    // T3: in_valid gaps, roughly 30% duty
    for (int k = 0; k < NI; k++) begin
      while ($urandom_range(0, 9) >= 3) @(negedge clk);
      send(16'd1 + 16'(k));
    end
    push_seq(16'd1);
    wait_burst_end();
    pulse_done();

    // T4: reset aborts a partial fill
    for (int k = 0; k < 5; k++) send(16'd100 + 16'(k));
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("t4_out_valid_in_rst", 64'(out_valid), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("t4_out_valid_after_rst", 64'(out_valid), 64'd0);
    check("t4_ready_after_rst", 64'(in_ready), 64'd1);
    send_vec(16'd1);
    push_seq(16'd1);
    wait_burst_end();
    check("t4_out_valid_after_burst", 64'(out_valid), 64'd0);
    pulse_done();

    // T5: stray layer_done in FILL and BURST, data across the sign boundary
    send(16'h7FFC);
    send(16'h7FFD);
    pulse_done();
    check("t5_err_fill", 64'(done_err), 64'd1);
    check("t5_busy_fill", 64'(busy), 64'd0);
    for (int k = 2; k < NI; k++) send(16'h7FFC + 16'(k));
    push_seq(16'h7FFC);
    pulse_done();
    wait_burst_end();
    check("t5_err_sticky", 64'(done_err), 64'd1);
    check("t5_still_wait", 64'(busy), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("t5_err_cleared", 64'(done_err), 64'd0);

    // T5b: layer_done on the final beat is an error and does not release
    send_vec(16'd40);
    push_seq(16'd40);
    n = 0;
    while (!out_valid && n < 20) begin @(negedge clk); n++; end
    @(negedge clk);
    layer_done = 1'b1;
    @(negedge clk);
    layer_done = 1'b0;
    check("t5b_err_last_beat", 64'(done_err), 64'd1);
    check("t5b_still_busy", 64'(busy), 64'd1);
    pulse_done();
    check("t5b_released", 64'(in_ready), 64'd1);

    @(negedge clk);
    check("sb_drained", 64'(exp_q.size()), 64'd0);

    // T6: default parameters with a neuron model, three vectors
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    fork
      big_sender();
      big_neuron();
    join
    check("big_done_err", 64'(b_done_err), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
